// File: rtl/avalon_burst_read_slave.sv
// Avalon-MM burst read responder: queued commands, in-order beats after a fixed read latency,
// data = beat address ^ DATA_SEED.
//   state   | meaning
//   S_IDLE  | no burst active; pops the queue head when one is waiting
//   S_BURST | issuing beats of the current command, one per unstalled cycle
module avalon_burst_read_slave #(
    parameter int MAXBURSTCOUNT   = 16,
    parameter int BURSTCOUNTWIDTH = 5,
    parameter int DATAWIDTH       = 32,
    parameter int BYTEENABLEWIDTH = 4,
    parameter int ADDRESSWIDTH    = 32,
    parameter int CMDDEPTH        = 4,
    parameter int CMDDEPTH_LOG2   = 2,
    parameter int READLATENCY     = 2,
    parameter logic [31:0] DATA_SEED = 32'hA5A5_0000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [ADDRESSWIDTH-1:0]    slave_address,
    input  logic                       slave_read,
    input  logic [BURSTCOUNTWIDTH-1:0] slave_burstcount,
    input  logic [BYTEENABLEWIDTH-1:0] slave_byteenable,
    output logic                       slave_waitrequest,
    output logic                       slave_readdatavalid,
    output logic [DATAWIDTH-1:0]       slave_readdata,
    input  logic                       stall_inject,
    input  logic                       beat_stall,
    output logic                       protocol_err,
    output logic [31:0]                beats_returned
);
    localparam int CW = CMDDEPTH_LOG2 + 1;
    localparam int XW = (ADDRESSWIDTH > 32) ? ADDRESSWIDTH : 32;
    localparam logic [BURSTCOUNTWIDTH-1:0] MAXBC = BURSTCOUNTWIDTH'(MAXBURSTCOUNT);

    typedef enum logic {S_IDLE, S_BURST} state_t;

    state_t                      state_q, state_d;
    logic [ADDRESSWIDTH-1:0]     addr_q, addr_d;
    logic [BURSTCOUNTWIDTH-1:0]  rem_q, rem_d;

    logic [ADDRESSWIDTH-1:0]     q_addr [CMDDEPTH];
    logic [BURSTCOUNTWIDTH-1:0]  q_len  [CMDDEPTH];
    logic [CMDDEPTH_LOG2-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]               cmd_count;

    logic                        cmd_take, push, pop, bad_cmd, beat_issue;
    logic [BURSTCOUNTWIDTH-1:0]  len_in;
    logic [DATAWIDTH-1:0]        beat_data;
    logic [READLATENCY-1:0]      vld_q;
    logic [DATAWIDTH-1:0]        data_q [READLATENCY];
    logic                        unused_byteenable;

    assign unused_byteenable = ^slave_byteenable;

    assign slave_waitrequest = reset | stall_inject | (cmd_count == CW'(CMDDEPTH));
    assign cmd_take = slave_read & ~slave_waitrequest;
    assign push     = cmd_take & (slave_burstcount != '0);
    assign bad_cmd  = cmd_take & ((slave_burstcount == '0) | (slave_burstcount > MAXBC));
    assign len_in   = (slave_burstcount > MAXBC) ? MAXBC : slave_burstcount;
    assign beat_data = DATAWIDTH'(XW'(addr_q) ^ XW'(DATA_SEED));

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rem_d      = rem_q;
        pop        = 1'b0;
        beat_issue = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmd_count != '0) begin
                    pop     = 1'b1;
                    state_d = S_BURST;
                    addr_d  = q_addr[rd_ptr];
                    rem_d   = q_len[rd_ptr];
                end
            end
            S_BURST: begin
                if (!beat_stall) begin
                    beat_issue = 1'b1;
                    if (rem_q == BURSTCOUNTWIDTH'(1)) begin
                        // chain straight into the next command so bursts have no bubble
                        if (cmd_count != '0) begin
                            pop    = 1'b1;
                            addr_d = q_addr[rd_ptr];
                            rem_d  = q_len[rd_ptr];
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        addr_d = addr_q + ADDRESSWIDTH'(BYTEENABLEWIDTH);
                        rem_d  = rem_q - BURSTCOUNTWIDTH'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            rem_q        <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            cmd_count    <= '0;
            protocol_err <= 1'b0;
            for (int i = 0; i < CMDDEPTH; i++) begin
                q_addr[i] <= '0;
                q_len[i]  <= '0;
            end
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            if (push) begin
                q_addr[wr_ptr] <= slave_address;
                q_len[wr_ptr]  <= len_in;
                wr_ptr         <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            cmd_count <= cmd_count + CW'(push) - CW'(pop);
            if (bad_cmd)
                protocol_err <= 1'b1;
        end
    end

    // latency pipe: each stage holds its data when no beat passes through it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q          <= '0;
            beats_returned <= '0;
            for (int i = 0; i < READLATENCY; i++)
                data_q[i] <= '0;
        end else begin
            vld_q[0] <= beat_issue;
            if (beat_issue)
                data_q[0] <= beat_data;
            for (int i = 1; i < READLATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
                if (vld_q[i-1])
                    data_q[i] <= data_q[i-1];
            end
            if (slave_readdatavalid)
                beats_returned <= beats_returned + 32'd1;
        end
    end

    assign slave_readdatavalid = vld_q[READLATENCY-1];
    assign slave_readdata      = data_q[READLATENCY-1];
endmodule

// File: tb/tb_avalon_burst_read_slave.sv
// Scoreboard bench for avalon_burst_read_slave: stimulus pushes expected beats, a negedge
// monitor pops and compares every returned beat.
module tb_avalon_burst_read_slave;
    localparam logic [31:0] SEED = 32'hA5A5_0000;

    logic        clk, reset;
    logic [31:0] slave_address;
    logic        slave_read;
    logic [4:0]  slave_burstcount;
    logic [3:0]  slave_byteenable;
    logic        slave_waitrequest, slave_readdatavalid;
    logic [31:0] slave_readdata;
    logic        stall_inject, beat_stall, protocol_err;
    logic [31:0] beats_returned;

    avalon_burst_read_slave dut (
        .clk(clk), .reset(reset),
        .slave_address(slave_address), .slave_read(slave_read),
        .slave_burstcount(slave_burstcount), .slave_byteenable(slave_byteenable),
        .slave_waitrequest(slave_waitrequest), .slave_readdatavalid(slave_readdatavalid),
        .slave_readdata(slave_readdata), .stall_inject(stall_inject),
        .beat_stall(beat_stall), .protocol_err(protocol_err),
        .beats_returned(beats_returned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt++;

    logic [31:0] sb[$];
    int vectors = 0, miscompares = 0;
    int nvalid = 0, first_v = 0, last_v = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && slave_readdatavalid) begin
            if (nvalid == 0) first_v = edge_cnt;
            last_v = edge_cnt;
            nvalid++;
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_beat: got %h expected no beat (t=%0t)", slave_readdata, $time);
            end else begin
                check("beat_data", slave_readdata, sb.pop_front());
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic [4:0] bc, output int waits, output int acc_edge);
        waits = 0;
        @(negedge clk);
        slave_read = 1'b1;
        slave_address = a;
        slave_burstcount = bc;
        slave_byteenable = 4'hF;
        while (1) begin
            #1;
            if (!slave_waitrequest) break;
            waits++;
            if (waits >= 300) begin
                vectors++;
                miscompares++;
                $display("FAIL accept_timeout: got waitrequest=1 for %0d cycles expected accept", waits);
                break;
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        acc_edge = edge_cnt;
        slave_read = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (sb.size() != 0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
        check("drain_left", sb.size(), 0);
    endtask

    task automatic push_burst(input logic [31:0] a, input int n);
        for (int i = 0; i < n; i++) sb.push_back((a + 32'(4 * i)) ^ SEED);
    endtask

    int w, acc, wsum, w6, n_at_reset, tmo;

    initial begin
        reset = 1'b1;
        slave_read = 1'b0; slave_address = '0; slave_burstcount = '0;
        slave_byteenable = '0; stall_inject = 1'b0; beat_stall = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_waitrequest", slave_waitrequest, 1);
        check("rst_valid", slave_readdatavalid, 0);
        check("rst_data", slave_readdata, 0);
        check("rst_err", protocol_err, 0);
        check("rst_beats", beats_returned, 0);
        reset = 1'b0;
        @(negedge clk);
        check("stall_inject", {31'd0, slave_waitrequest}, 0);
        stall_inject = 1'b1;
        #1 check("stall_inject_on", slave_waitrequest, 1);
        stall_inject = 1'b0;

        // single burst, latency and hand-computed data
        nvalid = 0;
        sb.push_back(32'hA5A5_0100); sb.push_back(32'hA5A5_0104);
        sb.push_back(32'hA5A5_0108); sb.push_back(32'hA5A5_010C);
        issue(32'h100, 5'd4, w, acc);
        drain();
        check("first_latency", first_v - acc, 3);
        check("single_span", last_v - first_v, 3);
        check("single_beats", beats_returned, 4);

        // back-to-back 16-beat bursts
        nvalid = 0; wsum = 0;
        for (int c = 0; c < 4; c++) push_burst(32'h1000 + 32'(64 * c), 16);
        for (int c = 0; c < 4; c++) begin
            issue(32'h1000 + 32'(64 * c), 5'd16, w, acc);
            wsum += w;
        end
        drain();
        check("b2b_waits", wsum, 0);
        check("b2b_count", nvalid, 64);
        check("b2b_span", last_v - first_v, 63);
        check("b2b_beats", beats_returned, 68);

        // full queue while beats are stalled
        beat_stall = 1'b1; wsum = 0;
        for (int c = 0; c < 6; c++) push_burst(32'h2000 + 32'(16 * c), 2);
        for (int c = 0; c < 5; c++) begin
            issue(32'h2000 + 32'(16 * c), 5'd2, w, acc);
            wsum += w;
        end
        check("fill_waits", wsum, 0);
        fork
            issue(32'h2050, 5'd2, w6, acc);
            begin
                repeat (4) @(negedge clk);
                #2 check("full_waitrequest", slave_waitrequest, 1);
                beat_stall = 1'b0;
            end
        join
        drain();
        check("full_held", {31'd0, w6 >= 4}, 1);
        check("full_beats", beats_returned, 80);

        // illegal burstcounts
        nvalid = 0;
        check("err_clear", protocol_err, 0);
        issue(32'h4000, 5'd0, w, acc);
        repeat (10) @(negedge clk);
        check("zero_err", protocol_err, 1);
        check("zero_nobeats", nvalid, 0);
        push_burst(32'h5000, 16);
        issue(32'h5000, 5'd31, w, acc);
        drain();
        check("clamp_count", nvalid, 16);
        check("clamp_err", protocol_err, 1);
        check("clamp_beats", beats_returned, 96);

        // address wrap with stall toggling
        nvalid = 0;
        sb.push_back(32'h5A5A_FFF8); sb.push_back(32'h5A5A_FFFC);
        sb.push_back(32'hA5A5_0000); sb.push_back(32'hA5A5_0004);
        fork
            issue(32'hFFFF_FFF8, 5'd4, w, acc);
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                beat_stall = ~beat_stall;
            end
        join
        beat_stall = 1'b0;
        drain();
        check("wrap_count", nvalid, 4);
        check("wrap_gaps", {31'd0, (last_v - first_v) > 3}, 1);
        check("wrap_beats", beats_returned, 100);

        // reset mid-burst
        nvalid = 0;
        push_burst(32'h600, 8);
        issue(32'h600, 5'd8, w, acc);
        tmo = 0;
        while (nvalid < 2 && tmo < 50) begin
            @(negedge clk);
            #2 tmo++;
        end
        check("midburst_reached", nvalid, 2);
        reset = 1'b1;
        sb.delete();
        n_at_reset = nvalid;
        #1;
        check("mid_rst_valid", slave_readdatavalid, 0);
        check("mid_rst_data", slave_readdata, 0);
        check("mid_rst_err", protocol_err, 0);
        check("mid_rst_beats", beats_returned, 0);
        check("mid_rst_wait", slave_waitrequest, 1);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_wait", slave_waitrequest, 0);
        repeat (20) @(negedge clk);
        check("post_rst_nobeats", nvalid, n_at_reset);
        check("post_rst_beats", beats_returned, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
